// File: rtl/cpu_stack_seq.sv
// Stack-page push/pop sequencer for the 6502 core: runs 8/16-bit stack transfers on the
// memory bus and returns the final SP to the register file with a one-cycle sp_write strobe.
module cpu_stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  input  logic [7:0]  sp_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  sp_out,
  output logic        sp_write,
  output logic        rsp_valid,
  output logic [15:0] rsp_data
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_LO, CAP_LO, RD_HI, CAP_HI, DONE} state_t;

  state_t      state_q, state_d;
  logic        wide_q, wide_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  sp_q, sp_d;
  logic        ready_q, ready_d;
  logic        cap_lo_q, cap_lo_d, cap_hi_q, cap_hi_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d, re_q, re_d;
  logic [7:0]  sp_out_q, sp_out_d;
  logic        sp_write_q, sp_write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_q, rsp_d;
  logic [7:0]  sp_inc, sp_dec;

  assign sp_inc = sp_q + 8'd1;
  assign sp_dec = sp_q - 8'd1;

  always_comb begin
    state_d     = state_q;
    wide_d      = wide_q;
    data_d      = data_q;
    sp_d        = sp_q;
    ready_d     = ready_q;
    cap_lo_d    = 1'b0;
    cap_hi_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    sp_out_d    = sp_out_q;
    sp_write_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    // Read data arrives the cycle after mem_re, so the byte lands one edge after CAP_*.
    if (cap_lo_q) rsp_d[7:0]  = mem_rdata;
    if (cap_hi_q) rsp_d[15:8] = mem_rdata;
    unique case (state_q)
      IDLE: if (cmd_valid && ready_q) begin
        wide_d  = cmd_op[0];
        data_d  = cmd_data;
        sp_d    = sp_in;
        rsp_d   = 16'h0000;
        ready_d = 1'b0;
        unique case (cmd_op)
          2'b00:   state_d = WR_LO;
          2'b01:   state_d = WR_HI;
          default: state_d = RD_LO;
        endcase
      end
      WR_HI: begin
        we_d    = 1'b1;
        addr_d  = {STACK_PAGE, sp_q};
        wdata_d = data_q[15:8];
        sp_d    = sp_dec;
        state_d = WR_LO;
      end
      WR_LO: begin
        we_d    = 1'b1;
        addr_d  = {STACK_PAGE, sp_q};
        wdata_d = data_q[7:0];
        sp_d    = sp_dec;
        state_d = DONE;
      end
      RD_LO: begin
        re_d    = 1'b1;
        addr_d  = {STACK_PAGE, sp_inc};
        sp_d    = sp_inc;
        state_d = CAP_LO;
      end
      CAP_LO: begin
        cap_lo_d = 1'b1;
        state_d  = wide_q ? RD_HI : DONE;
      end
      RD_HI: begin
        re_d    = 1'b1;
        addr_d  = {STACK_PAGE, sp_inc};
        sp_d    = sp_inc;
        state_d = CAP_HI;
      end
      CAP_HI: begin
        cap_hi_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        sp_write_d  = 1'b1;
        sp_out_d    = sp_q;
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wide_q      <= 1'b0;
      data_q      <= 16'h0000;
      sp_q        <= 8'h00;
      ready_q     <= 1'b1;
      cap_lo_q    <= 1'b0;
      cap_hi_q    <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      sp_out_q    <= 8'h00;
      sp_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wide_q      <= wide_d;
      data_q      <= data_d;
      sp_q        <= sp_d;
      ready_q     <= ready_d;
      cap_lo_q    <= cap_lo_d;
      cap_hi_q    <= cap_hi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      sp_out_q    <= sp_out_d;
      sp_write_q  <= sp_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign sp_out    = sp_out_q;
  assign sp_write  = sp_write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_cpu_stack_seq.sv
// Bench for cpu_stack_seq: directed vector table, hand-written reset/back-pressure
// sequences, then random commands checked against a stack-page reference model.
module tb_cpu_stack_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0000;
  logic [7:0]  sp_in = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  sp_out;
  logic        sp_write, rsp_valid;
  logic [15:0] rsp_data;

  int checks = 0;
  int errors = 0;

  cpu_stack_seq #(.STACK_PAGE(8'h01)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .sp_in(sp_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sp_out(sp_out), .sp_write(sp_write),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_re.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Results of the most recent command, observed on the bus.
  int          r_lat, r_nw, r_nr;
  logic [7:0]  r_sp;
  logic [15:0] r_rsp;
  logic [15:0] r_wa [4];
  logic [7:0]  r_wd [4];
  logic [15:0] r_ra [4];
  bit          r_both, r_rv;

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] d, input logic [7:0] sp);
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; sp_in = sp;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    r_lat = -1; r_nw = 0; r_nr = 0; r_both = 0; r_rv = 0;
    r_sp = 8'h00; r_rsp = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we && mem_re) r_both = 1;
      if (mem_we && r_nw < 4) begin r_wa[r_nw] = mem_addr; r_wd[r_nw] = mem_wdata; r_nw++; end
      if (mem_re && r_nr < 4) begin r_ra[r_nr] = mem_addr; r_nr++; end
      if (sp_write) begin
        r_lat = c; r_sp = sp_out; r_rsp = rsp_data; r_rv = rsp_valid;
        break;
      end
    end
    chk("no_we_re_overlap", r_both, 0);
    chk("rsp_valid_with_sp_write", r_rv, 1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [7:0]  sp;
    bit          pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_val;
    int          lat;
    logic [7:0]  exp_sp;
    logic [15:0] exp_rsp;
    int          nbytes;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
  } vec_t;

  vec_t vt [5];
  logic [7:0] shadow [256];

  initial begin
    vt[0] = '{2'b00, 16'h0055, 8'hFF, 0, 16'h0, 8'h0,  2, 8'hFE, 16'h0000, 1, 16'h01FF, 16'h0,    8'h55, 8'h00};
    vt[1] = '{2'b01, 16'h1234, 8'hFD, 0, 16'h0, 8'h0,  3, 8'hFB, 16'h0000, 2, 16'h01FD, 16'h01FC, 8'h12, 8'h34};
    vt[2] = '{2'b11, 16'h0000, 8'hFB, 0, 16'h0, 8'h0,  5, 8'hFD, 16'h1234, 2, 16'h01FC, 16'h01FD, 8'h00, 8'h00};
    vt[3] = '{2'b01, 16'hABCD, 8'h00, 0, 16'h0, 8'h0,  3, 8'hFE, 16'h0000, 2, 16'h0100, 16'h01FF, 8'hAB, 8'hCD};
    vt[4] = '{2'b10, 16'h0000, 8'hFF, 1, 16'h0100, 8'h77, 3, 8'h00, 16'h0077, 1, 16'h0100, 16'h0, 8'h00, 8'h00};

    for (int i = 0; i < 256; i++) mem[{8'h01, i[7:0]}] = 8'h00;

    // Reset state
    #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_sp_write", sp_write, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Reset mid-PUSH16 aborts it
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 16'h5566; sp_in = 8'h80;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_we_active", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_sp_out", sp_out, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {sp_write, rsp_valid, mem_we, mem_re}, 4'b0000);
      chk("post_rst_ready", cmd_ready, 1);
    end

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      if (vt[i].pre_en) mem[vt[i].pre_addr] = vt[i].pre_val;
      run_cmd(vt[i].op, vt[i].data, vt[i].sp);
      chk($sformatf("vec%0d_latency", i), r_lat, vt[i].lat);
      chk($sformatf("vec%0d_sp_out", i), r_sp, vt[i].exp_sp);
      chk($sformatf("vec%0d_rsp_data", i), r_rsp, vt[i].exp_rsp);
      if (vt[i].op[1]) begin
        chk($sformatf("vec%0d_nreads", i), r_nr, vt[i].nbytes);
        chk($sformatf("vec%0d_nwrites", i), r_nw, 0);
        chk($sformatf("vec%0d_raddr0", i), r_ra[0], vt[i].a0);
        if (vt[i].nbytes == 2) chk($sformatf("vec%0d_raddr1", i), r_ra[1], vt[i].a1);
      end else begin
        chk($sformatf("vec%0d_nwrites", i), r_nw, vt[i].nbytes);
        chk($sformatf("vec%0d_nreads", i), r_nr, 0);
        chk($sformatf("vec%0d_waddr0", i), r_wa[0], vt[i].a0);
        chk($sformatf("vec%0d_wdata0", i), r_wd[0], vt[i].d0);
        if (vt[i].nbytes == 2) begin
          chk($sformatf("vec%0d_waddr1", i), r_wa[1], vt[i].a1);
          chk($sformatf("vec%0d_wdata1", i), r_wd[1], vt[i].d1);
        end
      end
    end

    // cmd_valid held through a POP16 while cmd_op/sp_in wander
    begin
      bit stray_we, early_done;
      stray_we = 0; early_done = 0;
      mem[16'h0111] = 8'h3C; mem[16'h0112] = 8'hC3;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11; sp_in = 8'h10;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("hold_busy_ready", cmd_ready, 0);
        if (mem_we) stray_we = 1;
        if (sp_write) early_done = 1;
        if (c == 1) chk("hold_rd_lo_addr", {mem_re, mem_addr}, {1'b1, 16'h0111});
        cmd_op = 2'($urandom_range(0, 2));
        sp_in = 8'($urandom);
      end
      chk("hold_no_stray_write", stray_we, 0);
      chk("hold_no_early_done", early_done, 0);
      @(negedge clk);
      chk("hold_done_sp_write", sp_write, 1);
      chk("hold_done_sp_out", sp_out, 8'h12);
      chk("hold_done_rsp", rsp_data, 16'hC33C);
      chk("hold_ready_after_done", cmd_ready, 1);
      cmd_op = 2'b00; cmd_data = 16'h0099; sp_in = 8'h40;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("second_accepted", cmd_ready, 0);
      @(negedge clk);
      chk("second_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0140, 8'h99});
      @(negedge clk);
      chk("second_done", {sp_write, sp_out}, {1'b1, 8'h3F});
    end

    // Random commands vs. stack-page reference model
    for (int i = 0; i < 256; i++) begin
      shadow[i] = 8'($urandom);
      mem[{8'h01, i[7:0]}] = shadow[i];
    end
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [15:0] d, ersp;
      logic [7:0]  sp, esp, p1, p2;
      int          elat;
      logic [15:0] ea [2];
      logic [7:0]  ed [2];
      int          ecnt;
      op = 2'($urandom);
      d  = 16'($urandom);
      case ($urandom_range(0, 5))
        0: sp = 8'h00;
        1: sp = 8'hFF;
        2: sp = 8'h01;
        3: sp = 8'hFE;
        default: sp = 8'($urandom);
      endcase
      p1 = sp + 8'd1; p2 = sp + 8'd2;
      ersp = 16'h0000; ecnt = 0;
      ea[0] = 16'h0; ea[1] = 16'h0; ed[0] = 8'h0; ed[1] = 8'h0;
      case (op)
        2'b00: begin
          elat = 2; esp = sp - 8'd1; ecnt = 1;
          ea[0] = {8'h01, sp}; ed[0] = d[7:0];
          shadow[sp] = d[7:0];
        end
        2'b01: begin
          elat = 3; esp = sp - 8'd2; ecnt = 2;
          ea[0] = {8'h01, sp}; ed[0] = d[15:8];
          ea[1] = {8'h01, 8'(sp - 8'd1)}; ed[1] = d[7:0];
          shadow[sp] = d[15:8];
          shadow[8'(sp - 8'd1)] = d[7:0];
        end
        2'b10: begin
          elat = 3; esp = p1; ecnt = 1;
          ea[0] = {8'h01, p1};
          ersp = {8'h00, shadow[p1]};
        end
        default: begin
          elat = 5; esp = p2; ecnt = 2;
          ea[0] = {8'h01, p1}; ea[1] = {8'h01, p2};
          ersp = {shadow[p2], shadow[p1]};
        end
      endcase
      run_cmd(op, d, sp);
      chk($sformatf("rnd%0d_latency", n), r_lat, elat);
      chk($sformatf("rnd%0d_sp_out", n), r_sp, esp);
      chk($sformatf("rnd%0d_rsp", n), r_rsp, ersp);
      chk($sformatf("rnd%0d_count", n), op[1] ? r_nr : r_nw, ecnt);
      chk($sformatf("rnd%0d_other_count", n), op[1] ? r_nw : r_nr, 0);
      for (int k = 0; k < ecnt; k++) begin
        if (op[1]) chk($sformatf("rnd%0d_raddr%0d", n, k), r_ra[k], ea[k]);
        else begin
          chk($sformatf("rnd%0d_waddr%0d", n, k), r_wa[k], ea[k]);
          chk($sformatf("rnd%0d_wdata%0d", n, k), r_wd[k], ed[k]);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
